// File: rtl/hyperbus_pkg.sv
// Shared CA word layout, FSM state encoding and CA builder for the HyperBus command generator.
package hyperbus_pkg;

    localparam int CA_W         = 48;
    localparam int CA_RW_BIT    = 47;
    localparam int CA_AS_BIT    = 46;
    localparam int CA_BURST_BIT = 45;
    localparam int CA_UPPER_MSB = 44;
    localparam int CA_UPPER_LSB = 16;
    localparam int CA_LOWER_MSB = 2;
    localparam int CA_LOWER_LSB = 0;
    localparam int UPPER_W      = CA_UPPER_MSB - CA_UPPER_LSB + 1;
    localparam int LOWER_W      = CA_LOWER_MSB - CA_LOWER_LSB + 1;
    localparam int RSVD_W       = CA_UPPER_LSB - CA_LOWER_MSB - 1;

    typedef struct packed {
        logic               rw;
        logic               as;
        logic               burst;
        logic [UPPER_W-1:0] upper_col;
        logic [RSVD_W-1:0]  rsvd;
        logic [LOWER_W-1:0] lower_col;
    } hyper_ca_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CA0       = 3'd1,
        ST_CA1       = 3'd2,
        ST_CA2       = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    // waddr is the zero-extended word address; bits above it are not representable in CA.
    function automatic hyper_ca_t build_ca(input logic write, input logic is_reg,
                                           input logic [UPPER_W+LOWER_W-1:0] waddr);
        hyper_ca_t ca;
        ca.rw        = ~write;
        ca.as        = is_reg;
        ca.burst     = 1'b1;
        ca.upper_col = waddr[UPPER_W+LOWER_W-1:LOWER_W];
        ca.rsvd      = '0;
        ca.lower_col = waddr[LOWER_W-1:0];
        return ca;
    endfunction

endpackage

// File: rtl/hyperbus_cmd_gen.sv
// Splits word-granular requests into bounded bursts and emits each burst's CA word as three beats.
// Define HYPERBUS_CMD_BOUNDARY_SPLIT_EN to keep segments inside MAX_BURST_WORDS-aligned windows.
module hyperbus_cmd_gen
    import hyperbus_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int LEN_W           = 16,
    parameter int MAX_BURST_WORDS = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic              req_reg_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [LEN_W-1:0]  req_len_i,
    output logic              ca_valid_o,
    input  logic              ca_ready_i,
    output logic [15:0]       ca_data_o,
    output logic              ca_last_o,
    output logic [LEN_W-1:0]  seg_words_o,
    output logic              seg_write_o,
    output logic              seg_last_o,
    input  logic              seg_done_i,
    output logic              busy_o
);

    state_t              r_state;
    logic [ADDR_W-2:0]   r_waddr;
    logic [LEN_W-1:0]    r_rem;
    logic [LEN_W-1:0]    r_seg;
    logic                r_write;
    logic                r_reg;
    logic                r_seg_write;
    logic                r_seg_last;
    hyper_ca_t           r_ca;
    logic                r_ready;
    logic                r_busy;
    logic                r_ca_valid;
    logic                r_ca_last;
    logic [15:0]         r_ca_data;

    state_t              w_state_nxt;
    logic [ADDR_W-2:0]   w_waddr_nxt;
    logic [LEN_W-1:0]    w_rem_nxt;
    logic                w_write_nxt;
    logic                w_reg_nxt;
    logic                w_load;
    logic [LEN_W-1:0]    w_room;
    logic [LEN_W-1:0]    w_seg_nxt;
    hyper_ca_t           w_ca_new;
    logic [CA_W-1:0]     w_ca_bits;
    logic [15:0]         w_beat;
    logic                w_unused_addr_lsb;

    assign w_unused_addr_lsb = req_addr_i[0];

    always_comb begin
        w_state_nxt = r_state;
        w_waddr_nxt = r_waddr;
        w_rem_nxt   = r_rem;
        w_write_nxt = r_write;
        w_reg_nxt   = r_reg;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid_i) begin
                    w_write_nxt = req_write_i;
                    w_reg_nxt   = req_reg_i;
                    w_waddr_nxt = req_addr_i[ADDR_W-1:1];
                    w_rem_nxt   = req_reg_i ? LEN_W'(1) : req_len_i;
                    if (w_rem_nxt != '0) begin
                        w_state_nxt = ST_CA0;
                        w_load      = 1'b1;
                    end
                end
            end
            ST_CA0: if (ca_ready_i) w_state_nxt = ST_CA1;
            ST_CA1: if (ca_ready_i) w_state_nxt = ST_CA2;
            ST_CA2: if (ca_ready_i) w_state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (seg_done_i) begin
                    w_rem_nxt   = r_rem - r_seg;
                    w_waddr_nxt = r_waddr + (ADDR_W-1)'(r_seg);
                    if (w_rem_nxt == '0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_CA0;
                        w_load      = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Segment size is derived from the post-update rem/waddr so it can be registered on CA0 entry.
`ifdef HYPERBUS_CMD_BOUNDARY_SPLIT_EN
    localparam logic [ADDR_W-2:0] WADDR_MASK = (ADDR_W-1)'(MAX_BURST_WORDS - 1);
    assign w_room = LEN_W'(MAX_BURST_WORDS) - LEN_W'(w_waddr_nxt & WADDR_MASK);
`else
    assign w_room = LEN_W'(MAX_BURST_WORDS);
`endif
    assign w_seg_nxt = (w_rem_nxt < w_room) ? w_rem_nxt : w_room;
    assign w_ca_new  = build_ca(w_write_nxt, w_reg_nxt, (UPPER_W+LOWER_W)'(w_waddr_nxt));
    assign w_ca_bits = w_load ? w_ca_new : r_ca;

    always_comb begin
        w_beat = '0;
        case (w_state_nxt)
            ST_CA0:  w_beat = w_ca_bits[47:32];
            ST_CA1:  w_beat = w_ca_bits[31:16];
            ST_CA2:  w_beat = w_ca_bits[15:0];
            default: w_beat = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_waddr     <= '0;
            r_rem       <= '0;
            r_seg       <= '0;
            r_write     <= 1'b0;
            r_reg       <= 1'b0;
            r_seg_write <= 1'b0;
            r_seg_last  <= 1'b0;
            r_ca        <= '0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_ca_valid  <= 1'b0;
            r_ca_last   <= 1'b0;
            r_ca_data   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_waddr <= w_waddr_nxt;
            r_rem   <= w_rem_nxt;
            r_write <= w_write_nxt;
            r_reg   <= w_reg_nxt;
            if (w_load) begin
                r_seg       <= w_seg_nxt;
                r_seg_write <= w_write_nxt;
                r_seg_last  <= (w_rem_nxt == w_seg_nxt);
                r_ca        <= w_ca_new;
            end
            r_ready    <= (w_state_nxt == ST_IDLE);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_ca_valid <= (w_state_nxt == ST_CA0) || (w_state_nxt == ST_CA1) ||
                          (w_state_nxt == ST_CA2);
            r_ca_last  <= (w_state_nxt == ST_CA2);
            r_ca_data  <= w_beat;
        end
    end

    assign req_ready_o = r_ready;
    assign busy_o      = r_busy;
    assign ca_valid_o  = r_ca_valid;
    assign ca_last_o   = r_ca_last;
    assign ca_data_o   = r_ca_data;
    assign seg_words_o = r_seg;
    assign seg_write_o = r_seg_write;
    assign seg_last_o  = r_seg_last;

endmodule

// File: tb/tb_hyperbus_cmd_gen.sv
// Directed self-checking bench for hyperbus_cmd_gen; expectations follow HYPERBUS_CMD_BOUNDARY_SPLIT_EN.
module tb_hyperbus_cmd_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_reg = 1'b0;
    logic [31:0] req_addr = '0;
    logic [15:0] req_len = '0;
    logic        ca_valid;
    logic        ca_ready = 1'b0;
    logic [15:0] ca_data;
    logic        ca_last;
    logic [15:0] seg_words;
    logic        seg_write;
    logic        seg_last;
    logic        seg_done = 1'b0;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    hyperbus_cmd_gen #(.ADDR_W(32), .LEN_W(16), .MAX_BURST_WORDS(256)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_reg_i(req_reg), .req_addr_i(req_addr), .req_len_i(req_len),
        .ca_valid_o(ca_valid), .ca_ready_i(ca_ready), .ca_data_o(ca_data), .ca_last_o(ca_last),
        .seg_words_o(seg_words), .seg_write_o(seg_write), .seg_last_o(seg_last),
        .seg_done_i(seg_done), .busy_o(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic issue_req(input logic w, input logic r, input logic [31:0] a, input logic [15:0] l);
        req_valid = 1'b1; req_write = w; req_reg = r; req_addr = a; req_len = l;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic collect_ca(output logic [15:0] b0, output logic [15:0] b1,
                              output logic [15:0] b2, output int n);
        int  c;
        bit  done;
        b0 = 16'hDEAD; b1 = 16'hDEAD; b2 = 16'hDEAD;
        n = 0; c = 0; done = 1'b0;
        ca_ready = 1'b1;
        while (!done && c < 20) begin
            if (ca_valid) begin
                case (n)
                    0: b0 = ca_data;
                    1: b1 = ca_data;
                    default: b2 = ca_data;
                endcase
                n++;
                if (ca_last || n >= 3) done = 1'b1;
            end
            @(negedge clk);
            c++;
        end
        ca_ready = 1'b0;
    endtask

    task automatic pulse_done();
        seg_done = 1'b1;
        @(negedge clk);
        seg_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        n_checks++; if (ca_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ca_valid: got %b expected 0", ca_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if ({ca_data, ca_last, seg_words, seg_write, seg_last} !== 35'd0) begin
            n_fail++; $display("FAIL reset_outputs: got data=%h last=%b words=%0d wr=%b slast=%b expected all 0",
                               ca_data, ca_last, seg_words, seg_write, seg_last);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_single();
        logic [15:0] b0, b1, b2;
        int n;
        issue_req(1'b0, 1'b0, 32'h0000_1000, 16'd4);
        n_checks++; if (ca_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 1'b0) begin
            n_fail++; $display("FAIL read_first_beat_timing: got valid=%b busy=%b ready=%b expected 1 1 0", ca_valid, busy, req_ready);
        end
        collect_ca(b0, b1, b2, n);
        n_checks++; if (n !== 3) begin n_fail++; $display("FAIL read_beat_count: got %0d expected 3", n); end
        n_checks++; if ({b0, b1, b2} !== {16'hA000, 16'h0100, 16'h0000}) begin
            n_fail++; $display("FAIL read_beats: got %h %h %h expected a000 0100 0000", b0, b1, b2);
        end
        n_checks++; if (seg_words !== 16'd4 || seg_last !== 1'b1 || seg_write !== 1'b0) begin
            n_fail++; $display("FAIL read_seg: got words=%0d last=%b wr=%b expected 4 1 0", seg_words, seg_last, seg_write);
        end
        n_checks++; if (ca_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL read_wait_state: got valid=%b busy=%b expected 0 1", ca_valid, busy);
        end
        pulse_done();
        n_checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL read_to_idle: got busy=%b ready=%b expected 0 1", busy, req_ready);
        end
    endtask

    task automatic test_split();
        logic [15:0] b0, b1, b2;
        logic [47:0] exp_beats [3];
        logic [15:0] exp_words [3];
        int n;
`ifdef HYPERBUS_CMD_BOUNDARY_SPLIT_EN
        exp_words = '{16'd253, 16'd256, 16'd91};
        exp_beats = '{{16'h2000, 16'h0000, 16'h0003},
                      {16'h2000, 16'h0020, 16'h0000},
                      {16'h2000, 16'h0040, 16'h0000}};
`else
        exp_words = '{16'd256, 16'd256, 16'd88};
        exp_beats = '{{16'h2000, 16'h0000, 16'h0003},
                      {16'h2000, 16'h0020, 16'h0003},
                      {16'h2000, 16'h0040, 16'h0003}};
`endif
        issue_req(1'b1, 1'b0, 32'h0000_0006, 16'd600);
        for (int s = 0; s < 3; s++) begin
            collect_ca(b0, b1, b2, n);
            n_checks++; if ({b0, b1, b2} !== exp_beats[s] || n !== 3) begin
                n_fail++; $display("FAIL split_beats_seg%0d: got n=%0d %h %h %h expected 3 %h", s, n, b0, b1, b2, exp_beats[s]);
            end
            n_checks++; if (seg_words !== exp_words[s] || seg_last !== (s == 2) || seg_write !== 1'b1) begin
                n_fail++; $display("FAIL split_seg%0d: got words=%0d last=%b wr=%b expected %0d %b 1",
                                   s, seg_words, seg_last, seg_write, exp_words[s], (s == 2));
            end
            pulse_done();
        end
        n_checks++; if (busy !== 1'b0 || ca_valid !== 1'b0) begin
            n_fail++; $display("FAIL split_end_idle: got busy=%b valid=%b expected 0 0", busy, ca_valid);
        end
    endtask

    task automatic test_reg_write();
        logic [15:0] b0, b1, b2;
        int n;
        issue_req(1'b1, 1'b1, 32'h0000_0002, 16'd5);
        collect_ca(b0, b1, b2, n);
        n_checks++; if ({b0, b1, b2} !== {16'h6000, 16'h0000, 16'h0001} || n !== 3) begin
            n_fail++; $display("FAIL reg_beats: got n=%0d %h %h %h expected 3 6000 0000 0001", n, b0, b1, b2);
        end
        n_checks++; if (seg_words !== 16'd1 || seg_last !== 1'b1) begin
            n_fail++; $display("FAIL reg_seg: got words=%0d last=%b expected 1 1", seg_words, seg_last);
        end
        pulse_done();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reg_to_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_backpressure();
        issue_req(1'b0, 1'b0, 32'h0000_1000, 16'd4);
        n_checks++; if (ca_data !== 16'hA000) begin n_fail++; $display("FAIL bp_ca0: got %h expected a000", ca_data); end
        ca_ready = 1'b1;
        @(negedge clk);
        ca_ready = 1'b0;
        seg_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (ca_data !== 16'h0100 || ca_valid !== 1'b1 || ca_last !== 1'b0 || req_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold_%0d: got data=%h valid=%b last=%b ready=%b expected 0100 1 0 0",
                                   i, ca_data, ca_valid, ca_last, req_ready);
            end
            @(negedge clk);
        end
        n_checks++; if (ca_data !== 16'h0100) begin n_fail++; $display("FAIL bp_after_stall: got %h expected 0100", ca_data); end
        seg_done = 1'b0;
        ca_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (ca_data !== 16'h0000 || ca_last !== 1'b1 || ca_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_ca2: got data=%h last=%b valid=%b expected 0000 1 1", ca_data, ca_last, ca_valid);
        end
        @(negedge clk);
        ca_ready = 1'b0;
        n_checks++; if (ca_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_wait: got valid=%b busy=%b ready=%b expected 0 1 0", ca_valid, busy, req_ready);
        end
        pulse_done();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_to_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_len_zero();
        issue_req(1'b0, 1'b0, 32'h0000_0100, 16'd0);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (ca_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
                n_fail++; $display("FAIL len0_cycle%0d: got valid=%b ready=%b busy=%b expected 0 1 0", i, ca_valid, req_ready, busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_in_wait();
        logic [15:0] b0, b1, b2;
        int n;
        issue_req(1'b1, 1'b0, 32'h0000_0400, 16'd300);
        collect_ca(b0, b1, b2, n);
        n_checks++; if (busy !== 1'b1 || ca_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstw_in_wait: got busy=%b valid=%b expected 1 0", busy, ca_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (ca_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || seg_words !== 16'd0) begin
            n_fail++; $display("FAIL rstw_after: got valid=%b busy=%b ready=%b words=%0d expected 0 0 1 0",
                               ca_valid, busy, req_ready, seg_words);
        end
        seg_done = 1'b1;
        @(negedge clk);
        seg_done = 1'b0;
        n_checks++; if (ca_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstw_stays_idle: got valid=%b busy=%b expected 0 0", ca_valid, busy);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_read_single();
        test_split();
        test_reg_write();
        test_backpressure();
        test_len_zero();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hyperbus_cmd_gen.md
Name: hyperbus_cmd_gen

Overview:
- Transaction front-end directly upstream of the HyperBus controller/PHY.
- Accepts word-granular read/write requests, splits them into bounded bursts, and emits each burst's 48-bit Command-Address (CA) word as three 16-bit beats.
- Holds a per-segment descriptor stable until the PHY reports the data phase complete.

Parameters:
- ADDR_W, 32, byte-address width of requests.
- LEN_W, 16, width of request/segment length in 16-bit words.
- MAX_BURST_WORDS, 256, maximum words per segment; power of two, at most 2^(LEN_W-1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_write_i  in  1  1=write, 0=read
- req_reg_i  in  1  1=register address space
- req_addr_i  in  ADDR_W  byte address; bit 0 ignored
- req_len_i  in  LEN_W  length in 16-bit words
- ca_valid_o  out  1  CA beat valid
- ca_ready_i  in  1  CA beat consumed
- ca_data_o  out  16  CA beat
- ca_last_o  out  1  third CA beat
- seg_words_o  out  LEN_W  words in current segment
- seg_write_o  out  1  current segment direction
- seg_last_o  out  1  final segment of request
- seg_done_i  in  1  PHY finished current segment data phase
- busy_o  out  1  not IDLE

Behaviour:
- Interface: single clock clk_i; rst_i is synchronous, active-high.
- Reset: state IDLE. All outputs 0, except req_ready_o=1.
- Reset mid-operation: abort the transaction next edge with no further beats, and drop latched state.
- FSM states: IDLE, CA0, CA1, CA2, WAIT_DONE.
- IDLE:
  - req_ready_o=1 (registered).
  - On handshake, latch waddr=req_addr_i[ADDR_W-1:1], rem=req_len_i, write, reg.
  - If reg=1, force rem=1.
  - If rem==0, stay IDLE and emit nothing.
  - Otherwise go to CA0. First ca_valid_o is 1 cycle after accept.
- Segment size: seg = min(rem, MAX_BURST_WORDS). Registered on entry to CA0. seg_words_o/seg_write_o/seg_last_o are valid and stable from CA0 through WAIT_DONE.
- seg_last_o = (rem == seg).
- CA fields:
  - bit47 = ~write (1=read)
  - bit46 = reg
  - bit45 = 1 (linear burst)
  - bits44:16 = waddr[ADDR_W-2:3], zero-extended
  - bits15:3 = 0
  - bits2:0 = waddr[2:0]
- CA beats:
  - CA0 = CA[47:32], CA1 = CA[31:16], CA2 = CA[15:0].
  - ca_valid_o=1 in CA0..CA2. Advance only on ca_ready_i. ca_data_o is held under backpressure.
  - ca_last_o=1 in CA2. The CA2 handshake goes to WAIT_DONE.
- WAIT_DONE:
  - On seg_done_i: rem -= seg; waddr += seg (wraps modulo 2^(ADDR_W-1)).
  - If rem==0, go to IDLE; else go to CA0 for the next segment.
  - seg_done_i is ignored in every other state.
- busy_o = (state != IDLE).
- No combinational path from ca_ready_i or seg_done_i to any output.

Optional Feature:
- Macro: HYPERBUS_CMD_BOUNDARY_SPLIT_EN.
- Defined: seg = min(rem, MAX_BURST_WORDS - (waddr mod MAX_BURST_WORDS)). Segments never cross a MAX_BURST_WORDS-aligned boundary.
- Undefined: seg = min(rem, MAX_BURST_WORDS), with no alignment constraint.

Decomposition:
- hyperbus_pkg holds:
  - hyper_ca_t packed struct (rw, as, burst, upper_col, rsvd, lower_col)
  - CA bit-position constants
  - state enum
  - function build_ca(write, reg, waddr)
- No sub-module; the segment-size calculation stays inline.

Test Plan:
- Read, addr 0x0000_1000, len 4 -> beats 0xA000, 0x0100, 0x0000; seg_words=4; seg_last=1; one seg_done_i -> IDLE.
- Write, addr 0x6, len 600, macro off -> segments 256/256/88. Third segment beats 0x2000, 0x0040, 0x0003.
- Write, addr 0x6, len 600, macro on -> segments 253/256/91. Second segment starts at waddr 0x100.
- Register write, addr 0x2, len 5 -> one segment, seg_words=1, beats 0x6000, 0x0000, 0x0001.
- Backpressure: ca_ready_i low 3 cycles at CA1 -> ca_data_o held 0x0100, no beat lost. req_ready_o=0 throughout. Early seg_done_i in CA1 is ignored.
- len 0 -> accepted, no ca_valid_o, req_ready_o=1 next cycle. Separately, rst_i in WAIT_DONE -> next cycle ca_valid_o=0, busy_o=0, req_ready_o=1.
